// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - load-size encodings and default writeback entry type
package wb_pkg;

   localparam logic [1:0] LD_BYTE = 2'd0;
   localparam logic [1:0] LD_HALF = 2'd1;
   localparam logic [1:0] LD_WORD = 2'd2;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   typedef struct packed {
      logic [WB_DATA_W-1:0] data;
      logic [WB_ADDR_W-1:0] addr;
      logic                 we;
   } wb_entry_t;

endpackage

// File: rtl/wb_select_stage_if.sv
// rtl/wb_select_stage_if.sv - upstream entry and register-file write port bundle
interface wb_select_stage_if #(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = $clog2(NUM_SRC),
   parameter int ADDR_W  = 5
);
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [SEL_W-1:0]          src_sel;
   logic [ADDR_W-1:0]         rd_addr;
   logic                      reg_write;
   logic [1:0]                ld_size;
   logic                      ld_unsigned;
   logic [1:0]                byte_off;
   logic                      flush;
   logic                      wb_valid;
   logic                      wb_ready;
   logic [DATA_W-1:0]         wb_data;
   logic [ADDR_W-1:0]         wb_addr;
   logic                      wb_we;
   logic [31:0]               wb_count;

   modport master (
      output in_valid, src_data, src_sel, rd_addr, reg_write,
             ld_size, ld_unsigned, byte_off, flush, wb_ready,
      input  in_ready, wb_valid, wb_data, wb_addr, wb_we, wb_count
   );

   modport slave (
      input  in_valid, src_data, src_sel, rd_addr, reg_write,
             ld_size, ld_unsigned, byte_off, flush, wb_ready,
      output in_ready, wb_valid, wb_data, wb_addr, wb_we, wb_count
   );

endinterface

// File: rtl/wb_skid_buffer.sv
// rtl/wb_skid_buffer.sv - generic 2-entry valid/ready buffer with registered in_ready and flush
module wb_skid_buffer
   import wb_pkg::*;
#(
   parameter type entry_t = wb_entry_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   in_valid,
   output logic   in_ready,
   input  entry_t in_entry,
   output logic   out_valid,
   input  logic   out_ready,
   output entry_t out_entry
);

   entry_t skid_q;
   entry_t out_d;
   entry_t skid_d;
   logic   skid_valid;
   logic   out_valid_d;
   logic   skid_valid_d;
   logic   accept;
   logic   drain;

   always_comb begin
      accept       = in_valid & in_ready & ~flush;
      drain        = out_valid & out_ready & ~flush;
      out_d        = out_entry;
      skid_d       = skid_q;
      out_valid_d  = out_valid;
      skid_valid_d = skid_valid;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid) begin
         // full: in_ready is low, so only a drain can happen; skid moves up to keep order
         if (drain) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (out_valid) begin
         if (drain && accept) begin
            out_d = in_entry;
         end else if (drain) begin
            out_valid_d = 1'b0;
         end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
         end
      end else if (accept) begin
         out_d       = in_entry;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_entry  <= '0;
         skid_q     <= '0;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         out_entry  <= out_d;
         skid_q     <= skid_d;
         out_valid  <= out_valid_d;
         skid_valid <= skid_valid_d;
         // skid occupied implies output occupied, so a free skid slot means occupancy < 2
         in_ready   <= ~skid_valid_d;
      end
   end

endmodule

// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - registered writeback source select with skid-buffered write port
// (optional load extension under WB_LOAD_EXT_EN)
module wb_select_stage
   import wb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_SRC  = 4,
   parameter int SEL_W    = $clog2(NUM_SRC),
   parameter int ADDR_W   = 5,
   parameter int LOAD_SRC = 1
) (
   input logic               clk,
   input logic               rst,
   wb_select_stage_if.slave  bus
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic              we;
   } entry_t;

   logic [DATA_W-1:0] sel_data;
   entry_t            in_entry;
   entry_t            out_entry;
   logic              in_ready;
   logic              out_valid;
   logic [31:0]       count_q;

   // out-of-range selects fall through with zero data
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (int'(bus.src_sel) == i) sel_data = bus.src_data[i*DATA_W +: DATA_W];
      end
   end

`ifdef WB_LOAD_EXT_EN
   function automatic logic [DATA_W-1:0] load_extend(
      input logic [DATA_W-1:0] raw,
      input logic [1:0]        size,
      input logic              uns,
      input logic [1:0]        off
   );
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] res;
      sh = raw >> {off, 3'b000};
      case (size)
         LD_BYTE: res = {{(DATA_W-8){~uns & sh[7]}}, sh[7:0]};
         LD_HALF: begin
            sh  = raw >> {off[1], 4'b0000};
            res = {{(DATA_W-16){~uns & sh[15]}}, sh[15:0]};
         end
         LD_WORD: res = sh;
         default: res = sh;
      endcase
      return res;
   endfunction

   always_comb begin
      in_entry      = '0;
      in_entry.data = (int'(bus.src_sel) == LOAD_SRC)
                      ? load_extend(sel_data, bus.ld_size, bus.ld_unsigned, bus.byte_off)
                      : sel_data;
      in_entry.addr = bus.rd_addr;
      in_entry.we   = bus.reg_write & (|bus.rd_addr);
   end
`else
   logic unused_ld;
   assign unused_ld = ^{bus.ld_size, bus.ld_unsigned, bus.byte_off, (LOAD_SRC < 0)};

   always_comb begin
      in_entry      = '0;
      in_entry.data = sel_data;
      in_entry.addr = bus.rd_addr;
      in_entry.we   = bus.reg_write & (|bus.rd_addr);
   end
`endif

   wb_skid_buffer #(
      .entry_t (entry_t)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (in_ready),
      .in_entry  (in_entry),
      .out_valid (out_valid),
      .out_ready (bus.wb_ready),
      .out_entry (out_entry)
   );

   // a flush wins over the drain, so a handshake in the flush cycle is not a commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 32'd0;
      end else if (out_valid && bus.wb_ready && out_entry.we && !bus.flush) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.wb_valid = out_valid;
   assign bus.wb_data  = out_entry.data;
   assign bus.wb_addr  = out_entry.addr;
   assign bus.wb_we    = out_entry.we;
   assign bus.wb_count = count_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - directed and randomized checks against a queue model of the writeback stage
`timescale 1ns/1ps
module tb_wb_select_stage;

   localparam int DW = 32;
   localparam int NS = 4;
   localparam int SW = 3;
   localparam int AW = 5;
   localparam int LS = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_select_stage_if #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .ADDR_W(AW)) bus ();

   wb_select_stage #(
      .DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .ADDR_W(AW), .LOAD_SRC(LS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        we;
   } exp_t;

   exp_t        q[$];
   logic [31:0] exp_count;
   logic [31:0] src[NS];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] saved_count;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_data(input int sel, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
      logic [31:0] raw;
      logic [31:0] v;
      if (sel >= NS) return 32'h0;
      raw = src[sel];
`ifdef WB_LOAD_EXT_EN
      if (sel == LS) begin
         if (size == 2'd0) begin
            v = (raw >> (8 * int'(off))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            return v;
         end
         if (size == 2'd1) begin
            v = (raw >> (16 * (int'(off) / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            return v;
         end
         return raw >> (8 * int'(off));
      end
`endif
      v = raw;
      return v;
   endfunction

   task automatic compare_outputs();
      check("in_ready", bus.in_ready, q.size() < 2);
      check("wb_valid", bus.wb_valid, q.size() != 0);
      check("wb_count", bus.wb_count, exp_count);
      if (q.size() != 0) begin
         check("wb_data", bus.wb_data, q[0].data);
         check("wb_addr", bus.wb_addr, q[0].addr);
         check("wb_we", bus.wb_we, q[0].we);
      end
   endtask

   task automatic step();
      int   pre;
      bit   acc;
      bit   drn;
      exp_t e;
      for (int i = 0; i < NS; i++) bus.src_data[i*DW +: DW] = src[i];
      pre    = q.size();
      acc    = bus.in_valid && (pre < 2) && !bus.flush;
      drn    = (pre > 0) && bus.wb_ready && !bus.flush;
      e.data = model_data(int'(bus.src_sel), bus.ld_size, bus.ld_unsigned, bus.byte_off);
      e.addr = bus.rd_addr;
      e.we   = bus.reg_write && (bus.rd_addr != 5'd0);
      @(posedge clk);
      if (bus.flush) begin
         q.delete();
      end else begin
         if (drn) begin
            if (q[0].we) exp_count++;
            void'(q.pop_front());
         end
         if (acc) q.push_back(e);
      end
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic drive_entry(input int sel, input logic [4:0] rd, input logic we);
      bus.in_valid  = 1'b1;
      bus.src_sel   = 3'(sel);
      bus.rd_addr   = rd;
      bus.reg_write = we;
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.src_data    = '0;
      bus.src_sel     = '0;
      bus.rd_addr     = '0;
      bus.reg_write   = 1'b0;
      bus.ld_size     = 2'd2;
      bus.ld_unsigned = 1'b0;
      bus.byte_off    = 2'd0;
      bus.flush       = 1'b0;
      bus.wb_ready    = 1'b0;
      for (int i = 0; i < NS; i++) src[i] = 32'h0;
      exp_count = 32'd0;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_wb_valid", bus.wb_valid, 1'b0);
      check("rst_wb_data", bus.wb_data, 32'h0);
      check("rst_wb_addr", bus.wb_addr, 5'h0);
      check("rst_wb_we", bus.wb_we, 1'b0);
      check("rst_wb_count", bus.wb_count, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      compare_outputs();

      // basic select, one-cycle latency, commit count
      src[2] = 32'h0000_1234;
      bus.wb_ready = 1'b1;
      drive_entry(2, 5'd5, 1'b1);
      step();
      check("t1_valid", bus.wb_valid, 1'b1);
      check("t1_data", bus.wb_data, 32'h1234);
      check("t1_addr", bus.wb_addr, 5'd5);
      bus.in_valid = 1'b0;
      step();
      check("t1_count", bus.wb_count, 32'd1);

      // x0 destination never writes
      drive_entry(2, 5'd0, 1'b1);
      step();
      check("t2_valid", bus.wb_valid, 1'b1);
      check("t2_we", bus.wb_we, 1'b0);
      bus.in_valid = 1'b0;
      step();
      check("t2_count", bus.wb_count, 32'd1);

      // backpressure: A then B fill the stage, then drain in order
      bus.wb_ready = 1'b0;
      src[0] = 32'hAAAA_0001;
      drive_entry(0, 5'd3, 1'b1);
      step();
      src[0] = 32'hBBBB_0002;
      drive_entry(0, 5'd4, 1'b1);
      step();
      check("t3_full_in_ready", bus.in_ready, 1'b0);
      check("t3_head_a", bus.wb_data, 32'hAAAA_0001);
      bus.in_valid = 1'b0;
      bus.wb_ready = 1'b1;
      step();
      check("t3_head_b", bus.wb_data, 32'hBBBB_0002);
      check("t3_in_ready", bus.in_ready, 1'b1);
      step();
      check("t3_count", bus.wb_count, 32'd3);
      check("t3_empty", bus.wb_valid, 1'b0);

      // flush at occupancy 2 with a same-cycle entry
      bus.wb_ready = 1'b0;
      drive_entry(0, 5'd6, 1'b1);
      step();
      step();
      bus.flush = 1'b1;
      step();
      check("t4_valid", bus.wb_valid, 1'b0);
      check("t4_in_ready", bus.in_ready, 1'b1);
      check("t4_count", bus.wb_count, 32'd3);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      bus.wb_ready = 1'b1;
      step();
      check("t4_nothing", bus.wb_valid, 1'b0);

`ifdef WB_LOAD_EXT_EN
      src[1] = 32'h80FF_7F01;
      drive_entry(1, 5'd9, 1'b1);
      bus.ld_size = 2'd0; bus.byte_off = 2'd3; bus.ld_unsigned = 1'b0;
      step();
      check("t5_lb", bus.wb_data, 32'hFFFF_FF80);
      bus.ld_size = 2'd1; bus.byte_off = 2'd2; bus.ld_unsigned = 1'b1;
      step();
      check("t5_lhu", bus.wb_data, 32'h0000_80FF);
      bus.in_valid = 1'b0;
      bus.ld_size  = 2'd2; bus.byte_off = 2'd0;
      step();
`endif

      // out-of-range select
      src[3] = 32'hDEAD_BEEF;
      drive_entry(5, 5'd7, 1'b1);
      step();
      check("t6_data", bus.wb_data, 32'h0);
      check("t6_we", bus.wb_we, 1'b1);
      drive_entry(5, 5'd7, 1'b0);
      step();
      check("t6_we_off", bus.wb_we, 1'b0);
      bus.in_valid = 1'b0;
      step();

      // async reset while full
      bus.wb_ready = 1'b0;
      drive_entry(3, 5'd8, 1'b1);
      step();
      step();
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_in_ready", bus.in_ready, 1'b1);
      check("arst_wb_valid", bus.wb_valid, 1'b0);
      check("arst_wb_data", bus.wb_data, 32'h0);
      check("arst_wb_addr", bus.wb_addr, 5'h0);
      check("arst_wb_we", bus.wb_we, 1'b0);
      check("arst_wb_count", bus.wb_count, 32'h0);
      q.delete();
      exp_count = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      compare_outputs();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NS; i++) src[i] = $urandom;
         bus.in_valid    = ($urandom_range(0, 3) != 0);
         bus.src_sel     = 3'($urandom_range(0, 5));
         bus.rd_addr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         bus.reg_write   = ($urandom_range(0, 3) != 0);
         bus.ld_size     = 2'($urandom_range(0, 3));
         bus.ld_unsigned = 1'($urandom_range(0, 1));
         bus.byte_off    = 2'($urandom_range(0, 3));
         bus.flush       = ($urandom_range(0, 15) == 0);
         bus.wb_ready    = ($urandom_range(0, 2) != 0);
         step();
      end
      saved_count = exp_count;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.wb_ready = 1'b1;
      step();
      step();
      check("final_drained", bus.wb_valid, 1'b0);
      check("final_count_min", bus.wb_count >= saved_count, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
